fp_addsub_sched: RTL and testbench
==================================

Name: fp_addsub_sched

Overview:
- Round-robin scheduler that shares one fp_add_sub unit among N_REQ requesters.
- Arbitrates the requests, latches the winner's operands and issues a one-cycle start to the unit.
- Captures the result when the unit signals done, and returns it to the owning requester.
- Pulses the unit's reset between operations, because the unit requires a reset before each new start.
- Sits between the datapath clients and the single fp_add_sub instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RST_CYCLES, 1, cycles fp_reset is held high after each operation (>=1).
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; used only with FP_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held with its operands until gnt.
- req_op  in  N_REQ  per-requester operation: 0 = add, 1 = subtract (a - b).
- req_a  in  32*N_REQ  flattened operand A; slice i belongs to requester i.
- req_b  in  32*N_REQ  flattened operand B.
- gnt  out  N_REQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  N_REQ  one-hot, one-cycle result pulse to the owner.
- rsp_result  out  32  result; holds until the next rsp_valid.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout (feature only, else 0).
- busy  out  1  high in any state other than IDLE.
- fp_a1  out  32  operand A to the unit.
- fp_a2  out  32  operand B to the unit, sign-adjusted.
- fp_start  out  1  unit start pulse.
- fp_reset  out  1  unit reset, active-high.
- fp_result  in  32  unit result.
- fp_done  in  1  unit done.

Behaviour:
- Reset (reset low):
  - State goes to IDLE.
  - gnt, rsp_valid, rsp_err, fp_start, busy, fp_a1, fp_a2 and rsp_result all go to 0.
  - The round-robin pointer goes to 0.
  - fp_reset is forced to 1 combinationally while reset is low, so the unit clears even mid-operation.
- All outputs are registered, except that reset override on fp_reset.
- State machine:
  - IDLE: if req != 0, pick winner w as the first set bit at or after the pointer, wrapping around. Next cycle: state ISSUE, gnt[w] = 1, fp_start = 1, fp_a1 = A[w], fp_a2 = B[w] with bit 31 inverted when req_op[w] = 1; owner <= w.
  - ISSUE: one cycle only. Next cycle: WAIT, with gnt and fp_start back to 0.
  - WAIT:
    - fp_a1 and fp_a2 are held stable; req is ignored.
    - On fp_done: next cycle rsp_valid[owner] = 1, rsp_result = fp_result, state RECOVER, fp_reset = 1.
  - RECOVER:
    - fp_reset stays high for exactly RST_CYCLES cycles.
    - Then state IDLE, fp_reset = 0, pointer = (owner + 1) mod N_REQ.
- Latency:
  - req seen in IDLE at cycle t gives gnt at t+1.
  - fp_done at cycle d gives rsp_valid at d+1.
  - The earliest next gnt is d+2+RST_CYCLES.
- Handshake rules:
  - A requester drops req (or presents new operands) in the cycle after it sees gnt.
  - A req still high when IDLE is re-entered counts as a new request.
  - Operands are sampled only at the IDLE-to-ISSUE edge.
- Boundary conditions:
  - Simultaneous requests: the pointer decides; the pointer advances only on completion.
  - Wrap-around: pointer N_REQ-1 advances to 0.
  - fp_done in any state other than WAIT is ignored.
  - fp_start is never high while fp_reset is high.
- Special values: NaN and Inf operands are passed through unchanged; the unit handles them.

Optional Feature:
- FP_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse with no fp_done: rsp_valid[owner] = 1, rsp_err = 1, rsp_result = 32'h7FC00000, then RECOVER as normal.
  - The counter clears on entry to WAIT.
- Undefined: WAIT lasts indefinitely, rsp_err is tied 0 and no counter is synthesised.

Decomposition:
- Package fp_sched_pkg contains:
  - FP_W = 32.
  - FP_QNAN = 32'h7FC00000.
  - FP_SIGN_BIT = 31.
  - The state encoding IDLE/ISSUE/WAIT/RECOVER.
- One sub-module, fp_rr_arbiter: combinational priority pick from a req vector and a pointer, producing a one-hot grant and a winner index.

Test Plan:
- Requester 1 adds A = 0x3FE00000 (1.75) and B = 0x40500000 (3.25) -> gnt[1] one cycle later; fp_a2 = 0x40500000; rsp_valid[1] with rsp_result = 0x40A00000 (5.0); fp_reset high for RST_CYCLES.
- Requester 0 subtracts, A = 0x40500000 and B = 0x3FE00000 -> fp_a2 = 0xBFE00000; rsp_result = 0x3FC00000 (1.5).
- Requesters 0 and 2 request in the same cycle with pointer 0 -> gnt[0] first; gnt[2] after recovery; pointer then equals 3.
- All four hold req continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3; never two grants without an intervening rsp_valid.
- reset taken low in WAIT -> fp_reset = 1 immediately; all outputs 0; after release, a new request is served normally and the late fp_done is ignored.
- With FP_SCHED_TIMEOUT_EN and a unit stub that never asserts done -> rsp_valid after 64 WAIT cycles with rsp_err = 1, rsp_result = 0x7FC00000; the scheduler then returns to IDLE.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp_add_sub request scheduler.
package fp_sched_pkg;

  localparam int unsigned     FP_W        = 32;
  localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;
  localparam int unsigned     FP_SIGN_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_operands_t;

  // Subtraction is issued to the unit as an add with B's sign flipped.
  function automatic logic [FP_W-1:0] fp_apply_op(input logic [FP_W-1:0] b,
                                                  input logic            sub);
    logic [FP_W-1:0] r;
    r              = b;
    r[FP_SIGN_BIT] = b[FP_SIGN_BIT] ^ sub;
    return r;
  endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module fp_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0] win_c
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_c = '0;
    win_c = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_i) + i) % N_REQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        found                = 1'b1;
        gnt_c[IDX_W'(idx)]   = 1'b1;
        win_c                = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one fp_add_sub unit among N_REQ requesters.
// Optional WAIT-state timeout enabled by defining FP_SCHED_TIMEOUT_EN.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned RST_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_op,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]       rsp_result,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [FP_W-1:0]       fp_a1,
  output logic [FP_W-1:0]       fp_a2,
  output logic                  fp_start,
  output logic                  fp_reset,
  input  logic [FP_W-1:0]       fp_result,
  input  logic                  fp_done
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0]  rsp_result_q, rsp_result_d;
  fp_operands_t     opnd_q, opnd_d;
  logic             rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic             fp_start_q, fp_start_d, fp_reset_q, fp_reset_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_win;
  logic             timeout_c;

  fp_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_c (arb_gnt),
    .win_c (arb_win)
  );

`ifdef FP_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts only while waiting, so it is zero on every entry to WAIT.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign timeout_c = (state_q == WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = 1'b0;
    opnd_d       = opnd_q;
    fp_start_d   = 1'b0;
    fp_reset_d   = fp_reset_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    rst_cnt_d    = rst_cnt_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = ISSUE;
          gnt_d      = arb_gnt;
          fp_start_d = 1'b1;
          opnd_d.a   = req_a[arb_win*FP_W +: FP_W];
          opnd_d.b   = fp_apply_op(req_b[arb_win*FP_W +: FP_W], req_op[arb_win]);
          owner_d    = arb_win;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fp_done || timeout_c) begin
          state_d              = RECOVER;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_result_d         = fp_done ? fp_result : FP_QNAN;
          rsp_err_d            = timeout_c && !fp_done;
          fp_reset_d           = 1'b1;
          rst_cnt_d            = '0;
        end
      end
      RECOVER: begin
        // Pointer moves past the owner only once its operation has fully retired.
        if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
          state_d    = IDLE;
          fp_reset_d = 1'b0;
          ptr_d      = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        end else begin
          rst_cnt_d  = rst_cnt_q + RST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      opnd_q       <= '0;
      fp_start_q   <= 1'b0;
      fp_reset_q   <= 1'b0;
      ptr_q        <= '0;
      owner_q      <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      opnd_q       <= opnd_d;
      fp_start_q   <= fp_start_d;
      fp_reset_q   <= fp_reset_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign fp_a1      = opnd_q.a;
  assign fp_a2      = opnd_q.b;
  assign fp_start   = fp_start_q;
  // Reset reaches the unit immediately so it clears even mid-operation.
  assign fp_reset   = fp_reset_q | !reset;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed self-checking bench for fp_addsub_sched; unit responses are driven by hand.
module tb_fp_addsub_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, req_op;
  logic [127:0] req_a, req_b;
  logic [3:0]   gnt, rsp_valid;
  logic [31:0]  rsp_result, fp_a1, fp_a2, fp_result;
  logic         rsp_err, busy, fp_start, fp_reset, fp_done;

  int checks = 0;
  int errors = 0;
  bit outstanding = 1'b0;

  fp_addsub_sched #(.N_REQ(4), .RST_CYCLES(1), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .fp_a1      (fp_a1),
    .fp_a2      (fp_a2),
    .fp_start   (fp_start),
    .fp_reset   (fp_reset),
    .fp_result  (fp_result),
    .fp_done    (fp_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: grant, wait, unit done, result, recovery back to IDLE.
  task automatic run_op(input int w, input logic [31:0] ea1, input logic [31:0] ea2,
                        input logic [31:0] res, input logic [3:0] keep);
    tick();
    check_val("gnt", 32'(gnt), 32'(1) << w);
    check_val("fp_start", 32'(fp_start), 32'd1);
    check_val("fp_a1", fp_a1, ea1);
    check_val("fp_a2", fp_a2, ea2);
    check_val("busy_issue", 32'(busy), 32'd1);
    req = keep;
    tick();
    check_val("gnt_clear", 32'(gnt), 32'd0);
    check_val("start_clear", 32'(fp_start), 32'd0);
    tick();
    tick();
    check_val("fp_a1_hold", fp_a1, ea1);
    check_val("fp_a2_hold", fp_a2, ea2);
    check_val("busy_wait", 32'(busy), 32'd1);
    fp_result = res;
    fp_done   = 1'b1;
    tick();
    fp_done   = 1'b0;
    fp_result = 32'hDEAD_BEEF;
    check_val("rsp_valid", 32'(rsp_valid), 32'(1) << w);
    check_val("rsp_result", rsp_result, res);
    check_val("rsp_err", 32'(rsp_err), 32'd0);
    check_val("fp_reset_recover", 32'(fp_reset), 32'd1);
    tick();
    check_val("fp_reset_release", 32'(fp_reset), 32'd0);
    check_val("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    check_val("rsp_result_hold", rsp_result, res);
    check_val("busy_idle", 32'(busy), 32'd0);
  endtask

  // Grant exclusivity and start/reset separation, checked every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      outstanding = 1'b0;
    end else begin
      if (|gnt) begin
        check_val("gnt_overlap", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
      end
      if (|rsp_valid) outstanding = 1'b0;
      if (fp_start) check_val("start_in_reset", 32'(fp_reset), 32'd0);
    end
  end

  initial begin
    logic [31:0] a_tab [4];
    logic [31:0] b_tab [4];
    logic [31:0] a2_tab [4];
    logic [31:0] r_tab [4];
    int          n;

    a_tab  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    b_tab  = '{32'h3F00_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000};
    a2_tab = '{32'h3F00_0000, 32'hBF80_0000, 32'h7F80_0000, 32'hFFC0_0000};
    r_tab  = '{32'h3FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000};

    reset = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0;
    fp_done = 1'b0; fp_result = '0;
    tick();
    tick();
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fp_start", 32'(fp_start), 32'd0);
    check_val("rst_fp_reset", 32'(fp_reset), 32'd1);
    check_val("rst_fp_a1", fp_a1, 32'd0);
    check_val("rst_rsp_result", rsp_result, 32'd0);
    reset = 1'b1;
    tick();
    check_val("rel_fp_reset", 32'(fp_reset), 32'd0);

    // 1.75 + 3.25 from requester 1.
    req_a[32 +: 32] = 32'h3FE0_0000;
    req_b[32 +: 32] = 32'h4050_0000;
    req = 4'b0010;
    run_op(1, 32'h3FE0_0000, 32'h4050_0000, 32'h40A0_0000, 4'b0000);

    // 3.25 - 1.75 from requester 0 (pointer at 2 wraps to 0).
    req_a[0 +: 32] = 32'h4050_0000;
    req_b[0 +: 32] = 32'h3FE0_0000;
    req_op = 4'b0001;
    req = 4'b0001;
    run_op(0, 32'h4050_0000, 32'hBFE0_0000, 32'h3FC0_0000, 4'b0000);

    // Requester 3 completes, pointer wraps from 3 to 0.
    req_op = 4'b0000;
    req_a[96 +: 32] = 32'h4080_0000;
    req_b[96 +: 32] = 32'h3F00_0000;
    req = 4'b1000;
    run_op(3, 32'h4080_0000, 32'h3F00_0000, 32'h4090_0000, 4'b0000);

    // Simultaneous 0 and 2 with pointer 0.
    req_a[0 +: 32]  = 32'h3F80_0000; req_b[0 +: 32]  = 32'h3F80_0000;
    req_a[64 +: 32] = 32'h4040_0000; req_b[64 +: 32] = 32'h4000_0000;
    req = 4'b0101;
    run_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0100);
    run_op(2, 32'h4040_0000, 32'h4000_0000, 32'h40A0_0000, 4'b0000);

    // All four held: pointer at 3 grants 3 first, then 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = a_tab[i];
      req_b[i*32 +: 32] = b_tab[i];
    end
    req_op = 4'b1010;
    req = 4'b1111;
    run_op(3, a_tab[3], a2_tab[3], r_tab[3], 4'b1111);
    for (int k = 0; k < 8; k++) begin
      run_op(k % 4, a_tab[k % 4], a2_tab[k % 4], r_tab[k % 4], (k == 7) ? 4'b0000 : 4'b1111);
    end

    // Move pointer to 2, then interrupt an operation with reset in WAIT.
    req = 4'b0010;
    run_op(1, a_tab[1], a2_tab[1], r_tab[1], 4'b0000);
    req = 4'b0001;
    tick();
    check_val("pre_rst_gnt", 32'(gnt), 32'd1);
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_val("mid_rst_fp_reset", 32'(fp_reset), 32'd1);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_fp_a1", fp_a1, 32'd0);
    check_val("mid_rst_fp_a2", fp_a2, 32'd0);
    check_val("mid_rst_rsp_result", rsp_result, 32'd0);
    check_val("mid_rst_gnt", 32'(gnt), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    fp_result = 32'h1234_5678;
    fp_done   = 1'b1;
    tick();
    fp_done   = 1'b0;
    check_val("late_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("late_done_busy", 32'(busy), 32'd0);
    check_val("late_done_result", rsp_result, 32'd0);
    check_val("late_done_fp_reset", 32'(fp_reset), 32'd0);
    // Pointer was reset to 0: requester 1 wins over 2.
    req = 4'b0110;
    run_op(1, a_tab[1], a2_tab[1], r_tab[1], 4'b0100);
    run_op(2, a_tab[2], a2_tab[2], r_tab[2], 4'b0000);

`ifdef FP_SCHED_TIMEOUT_EN
    req = 4'b1000;
    tick();
    check_val("to_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    n = 0;
    while (rsp_valid == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    check_val("to_cycles", 32'(n), 32'd64);
    check_val("to_rsp_valid", 32'(rsp_valid), 32'h8);
    check_val("to_rsp_err", 32'(rsp_err), 32'd1);
    check_val("to_rsp_result", rsp_result, 32'h7FC0_0000);
    check_val("to_fp_reset", 32'(fp_reset), 32'd1);
    tick();
    check_val("to_busy_idle", 32'(busy), 32'd0);
    check_val("to_fp_reset_release", 32'(fp_reset), 32'd0);
`else
    n = 0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
